// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready skid register with synchronous flush and re-timed reset release.
// Optional PIPE_SKID_PERF_EN adds transfer/stall counters as extra output ports.
module pipe_skid_reg #(
  parameter int unsigned      WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_PERF_EN
  ,
  output logic [31:0]      perf_xfer_cnt,
  output logic [31:0]      perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [1:0]       rst_sync_q;
  logic             rst_int;
  logic             in_fire, out_fire;

  // Assertion is immediate; release is delayed by two clk edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync_q <= 2'b11;
    else     rst_sync_q <= {rst_sync_q[0], 1'b0};
  end

  assign rst_int = rst_sync_q[1];

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL) && !rst_int;
  assign out_data  = main_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_SKID_PERF_EN
  logic [31:0] xfer_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      xfer_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (out_fire)               xfer_cnt_q  <= xfer_cnt_q + 32'd1;
      if (out_valid && !out_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_xfer_cnt  = xfer_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  // Counters absent; datapath behaviour is identical.
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg (WIDTH=8, RESET_VAL=0xEE).
module tb_pipe_skid_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
`ifdef PIPE_SKID_PERF_EN
  logic [31:0] perf_xfer_cnt, perf_stall_cnt;
`endif

  int unsigned total = 0;
  int unsigned bad = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(
    .WIDTH(8),
    .RESET_VAL(8'hEE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
`ifdef PIPE_SKID_PERF_EN
    ,
    .perf_xfer_cnt(perf_xfer_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic r);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    if (v) chk({tag, ".out_data"}, 64'(out_data), 64'(d));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(r));
  endtask

  initial begin
    // Power-on reset
    tick(); tick();
    chk("por.out_valid", 64'(out_valid), 64'h0);
    chk("por.in_ready", 64'(in_ready), 64'h0);
    chk("por.out_data", 64'(out_data), 64'hEE);
    rst = 1'b0;
    tick();
    chk("por.rel1.in_ready", 64'(in_ready), 64'h0);
    tick();
    chk("por.rel2.in_ready", 64'(in_ready), 64'h1);
    chk("por.rel2.out_data", 64'(out_data), 64'hEE);

    // Streaming at full rate
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h11;
    tick(); chk_out("str0", 1'b1, 8'h11, 1'b1);
    in_data = 8'h22;
    tick(); chk_out("str1", 1'b1, 8'h22, 1'b1);
    in_data = 8'h33;
    tick(); chk_out("str2", 1'b1, 8'h33, 1'b1);
    in_valid = 1'b0;
    tick(); chk_out("str3", 1'b0, 8'h00, 1'b1);

    // Back-pressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h0A;
    tick(); chk_out("bp0", 1'b1, 8'h0A, 1'b1);
    in_data = 8'h0B;
    tick(); chk_out("bp1", 1'b1, 8'h0A, 1'b0);
    in_valid = 1'b0; in_data = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      tick(); chk_out($sformatf("bphold%0d", i), 1'b1, 8'h0A, 1'b0);
    end
    out_ready = 1'b1;
    tick(); chk_out("bp2", 1'b1, 8'h0B, 1'b1);
    tick(); chk_out("bp3", 1'b0, 8'h00, 1'b1);

    // Simultaneous in/out fire in BUSY
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h05;
    tick(); chk_out("sim0", 1'b1, 8'h05, 1'b1);
    in_data = 8'h06; out_ready = 1'b1;
    tick(); chk_out("sim1", 1'b1, 8'h06, 1'b1);
    in_valid = 1'b0;
    tick(); chk_out("sim2", 1'b0, 8'h00, 1'b1);

    // Flush from FULL with a presented word
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h01;
    tick();
    in_data = 8'h02;
    tick(); chk_out("fl.full", 1'b1, 8'h01, 1'b0);
    in_data = 8'h03; flush = 1'b1;
    tick(); chk_out("fl0", 1'b0, 8'h00, 1'b1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("fl.idle%0d", i), 64'(out_valid), 64'h0);
    end

    // Flush in BUSY discards a coincident in_fire
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h04;
    tick();
    in_data = 8'h08; flush = 1'b1;
    chk("flb.in_ready", 64'(in_ready), 64'h1);
    tick(); chk_out("flb0", 1'b0, 8'h00, 1'b1);
    flush = 1'b0; in_data = 8'h09;
    tick(); chk_out("flb1", 1'b1, 8'h09, 1'b1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); chk_out("flb2", 1'b0, 8'h00, 1'b1);

    // Asynchronous reset mid-cycle while FULL
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h0C;
    tick();
    in_data = 8'h0D;
    tick(); chk_out("rst.full", 1'b1, 8'h0C, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst.async.out_valid", 64'(out_valid), 64'h0);
    chk("rst.async.out_data", 64'(out_data), 64'hEE);
    chk("rst.async.in_ready", 64'(in_ready), 64'h0);
    tick();
    #2 rst = 1'b0;
    tick(); chk("rst.rel1.in_ready", 64'(in_ready), 64'h0);
    tick(); chk("rst.rel2.in_ready", 64'(in_ready), 64'h1);
    chk("rst.rel2.out_valid", 64'(out_valid), 64'h0);

`ifdef PIPE_SKID_PERF_EN
    // 10 transfers, 4 stall cycles, counted from the reset above
    chk("perf.clr.xfer", 64'(perf_xfer_cnt), 64'd0);
    chk("perf.clr.stall", 64'(perf_stall_cnt), 64'd0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h40;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      in_data = 8'(8'h40 + i);
      tick();
    end
    chk("perf.last_data", 64'(out_data), 64'h49);
    in_valid = 1'b0;
    tick();
    chk("perf.xfer", 64'(perf_xfer_cnt), 64'd10);
    chk("perf.stall", 64'(perf_stall_cnt), 64'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("perf.flush.xfer", 64'(perf_xfer_cnt), 64'd10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
